// File: rtl/hex_scroll_display_if.sv
// Host-side bundle of the message scroller: buffer writes, scroll control
// and the registered display outputs.
`timescale 1ns/1ps
interface hex_scroll_display_if #(
   parameter int NUM_DISP  = 4,
   parameter int MSG_DEPTH = 8
);
   localparam int AW = $clog2(MSG_DEPTH);
   localparam int LW = $clog2(MSG_DEPTH + 1);

   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic [4:0]              wr_data;
   logic [LW-1:0]           len;
   logic [1:0]              mode;
   logic                    run;
   logic                    step;
   logic [7*NUM_DISP-1:0]   HEX;
   logic [AW-1:0]           offset;
   logic                    tick;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      output len,
      output mode,
      output run,
      output step,
      input  HEX,
      input  offset,
      input  tick
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  len,
      input  mode,
      input  run,
      input  step,
      output HEX,
      output offset,
      output tick
   );
endinterface

// File: rtl/hex_scroll_display.sv
// Scrolls a NUM_DISP-wide window over a writable character buffer onto
// the seven-segment bank; left, right or bounce, auto-ticked or stepped.
`timescale 1ns/1ps
module hex_scroll_display #(
   parameter int TICK_CYCLES = 50000000,
   parameter int NUM_DISP    = 4,
   parameter int MSG_DEPTH   = 8
) (
   input logic                  clk,
   input logic                  rst,
   hex_scroll_display_if.slave  bus
);
   localparam int AW = $clog2(MSG_DEPTH);
   localparam int TW = $clog2(TICK_CYCLES);
   localparam int HW = 7 * NUM_DISP;

   localparam logic [0:0] DIR_L = 1'b0;
   localparam logic [0:0] DIR_R = 1'b1;

   logic [4:0]    mem [MSG_DEPTH];
   logic [TW-1:0] cnt;
   logic [AW-1:0] off_q;
   logic [AW-1:0] off_d;
   logic [0:0]    dir_q;
   logic [0:0]    dir_d;
   logic [HW-1:0] hex_q;
   logic [HW-1:0] hex_d;
   logic          tick_w;
   logic          adv;
   int            l_eff;

   function automatic logic [6:0] seg7(input logic [4:0] c);
      logic [6:0] s;
      unique case (c[3:0])
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h18;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return c[4] ? 7'h7F : s;
   endfunction

   always_comb begin
      l_eff = int'(bus.len);
      if (l_eff > MSG_DEPTH) begin
         l_eff = MSG_DEPTH;
      end
   end

   assign tick_w = bus.run && (cnt == TW'(TICK_CYCLES - 1));
   assign adv    = bus.run ? tick_w : bus.step;

   // Bounce walks toward M while dir is left (or when pinned at 0),
   // otherwise back toward 0; the flag flips on arrival at either end.
   always_comb begin
      int o;
      int m;
      int n;
      o     = int'(off_q);
      m     = l_eff - NUM_DISP;
      n     = o;
      off_d = off_q;
      dir_d = dir_q;
      if (o >= l_eff) begin
         off_d = '0;
      end else if (adv) begin
         unique case (bus.mode)
            2'b01: begin
               n = (o == 0) ? l_eff - 1 : o - 1;
            end
            2'b10: begin
               if (l_eff > NUM_DISP) begin
                  if (o > m) begin
                     n     = m;
                     dir_d = DIR_R;
                  end else if (o == 0 ||
                               (dir_q == DIR_L && o != m)) begin
                     n     = o + 1;
                     dir_d = (n == m) ? DIR_R : DIR_L;
                  end else begin
                     n     = o - 1;
                     dir_d = (n == 0) ? DIR_L : DIR_R;
                  end
               end
            end
            default: begin
               n = (o == l_eff - 1) ? 0 : o + 1;
            end
         endcase
         off_d = AW'(n);
      end
   end

   // A stale offset (len just shrank) renders from index 0 for one cycle.
   always_comb begin
      int idx;
      hex_d = '1;
      idx   = (int'(off_q) < l_eff) ? int'(off_q) : 0;
      if (l_eff != 0) begin
         for (int d = 0; d < NUM_DISP; d++) begin
            hex_d[HW-1-7*d -: 7] = seg7(mem[AW'(idx)]);
            idx = (idx == l_eff - 1) ? 0 : idx + 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         off_q <= '0;
         dir_q <= DIR_L;
         hex_q <= '1;
         for (int i = 0; i < MSG_DEPTH; i++) begin
            mem[i] <= 5'h10;
         end
      end else begin
         if (!bus.run || tick_w) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + TW'(1);
         end
         off_q <= off_d;
         dir_q <= dir_d;
         hex_q <= hex_d;
         if (bus.wr_en && int'(bus.wr_addr) < MSG_DEPTH) begin
            mem[bus.wr_addr] <= bus.wr_data;
         end
      end
   end

   assign bus.HEX    = hex_q;
   assign bus.offset = off_q;
   assign bus.tick   = tick_w;
endmodule

// File: tb/tb_hex_scroll_display.sv
// Scenario bench for hex_scroll_display with a small scoreboard queue.
`timescale 1ns/1ps
module tb_hex_scroll_display;
   localparam int TC = 4;
   localparam int ND = 4;
   localparam int MD = 8;

   typedef struct {
      int          off;
      logic        tk;
      logic        hc;
      logic [27:0] hx;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   logic [6:0] seg_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   hex_scroll_display_if #(.NUM_DISP(ND), .MSG_DEPTH(MD)) bus ();

   hex_scroll_display #(
      .TICK_CYCLES(TC),
      .NUM_DISP(ND),
      .MSG_DEPTH(MD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [27:0] rep4(input logic [6:0] s);
      return {s, s, s, s};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_buf(input int a, input logic [4:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(a);
      bus.wr_data = d;
      cyc();
      bus.wr_en = 1'b0;
   endtask

   task automatic home(input int l);
      bus.run  = 1'b0;
      bus.step = 1'b0;
      bus.len  = 4'd0;
      cyc();
      bus.len = 4'(l);
      cyc();
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'd0;
      bus.wr_data = 5'h05;
      bus.len     = 4'd1;
      bus.mode    = 2'b00;
      bus.run     = 1'b1;
      bus.step    = 1'b1;
      cyc();
      cyc();
      n_chk++;
      if (bus.HEX !== 28'hFFFFFFF) begin
         n_fail++;
         $display("FAIL reset_hex: got %h want fffffff", bus.HEX);
      end
      n_chk++;
      if (bus.offset !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_offset: got %0d want 0", bus.offset);
      end
      n_chk++;
      if (bus.tick !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tick: got %b want 0", bus.tick);
      end
      rst       = 1'b0;
      bus.wr_en = 1'b0;
      bus.run   = 1'b0;
      bus.step  = 1'b0;
      cyc();
      cyc();
      n_chk++;
      if (bus.HEX !== 28'hFFFFFFF) begin
         n_fail++;
         $display("FAIL reset_write_blocked: got %h want fffffff",
                  bus.HEX);
      end
   endtask

   task automatic test_scroll(input string nm, input logic [1:0] md,
                              input int seq[7], input int hat,
                              input logic [27:0] hx);
      exp_t e;
      int   c;
      home(6);
      bus.mode = md;
      for (int k = 0; k < 7 * TC; k++) begin
         e.off = seq[k / TC];
         e.tk  = (k % TC == TC - 1);
         e.hc  = (k == hat);
         e.hx  = hx;
         sb.push_back(e);
      end
      bus.run = 1'b1;
      c = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (bus.offset !== 3'(e.off)) begin
            n_fail++;
            $display("FAIL %s_offset c=%0d: got %0d want %0d",
                     nm, c, bus.offset, e.off);
         end
         n_chk++;
         if (bus.tick !== e.tk) begin
            n_fail++;
            $display("FAIL %s_tick c=%0d: got %b want %b",
                     nm, c, bus.tick, e.tk);
         end
         if (e.hc) begin
            n_chk++;
            if (bus.HEX !== e.hx) begin
               n_fail++;
               $display("FAIL %s_hex c=%0d: got %h want %h",
                        nm, c, bus.HEX, e.hx);
            end
         end
         cyc();
         c++;
      end
      bus.run = 1'b0;
   endtask

   task automatic test_step();
      exp_t e;
      int   nst;
      home(6);
      bus.mode = 2'b00;
      nst = 0;
      for (int c = 0; c < 6; c++) begin
         bus.step = (c % 2 == 0);
         if (bus.step) nst++;
         e.off = nst;
         e.tk  = 1'b0;
         e.hc  = 1'b0;
         e.hx  = '0;
         sb.push_back(e);
         cyc();
         e = sb.pop_front();
         n_chk++;
         if (bus.offset !== 3'(e.off) || bus.tick !== e.tk) begin
            n_fail++;
            $display("FAIL step_paused c=%0d: got off=%0d tick=%b want off=%0d tick=%b",
                     c, bus.offset, bus.tick, e.off, e.tk);
         end
      end
      bus.run  = 1'b1;
      bus.step = 1'b1;
      for (int c = 0; c < 6; c++) begin
         e.off = (c >= 3) ? 4 : 3;
         e.tk  = (c == 2);
         sb.push_back(e);
         cyc();
         e = sb.pop_front();
         n_chk++;
         if (bus.offset !== 3'(e.off) || bus.tick !== e.tk) begin
            n_fail++;
            $display("FAIL step_running c=%0d: got off=%0d tick=%b want off=%0d tick=%b",
                     c, bus.offset, bus.tick, e.off, e.tk);
         end
      end
      bus.run  = 1'b0;
      bus.step = 1'b0;
   endtask

   task automatic test_length();
      home(6);
      bus.mode = 2'b00;
      bus.step = 1'b1;
      repeat (5) cyc();
      bus.step = 1'b0;
      n_chk++;
      if (bus.offset !== 3'd5) begin
         n_fail++;
         $display("FAIL len_pre: got %0d want 5", bus.offset);
      end
      bus.len  = 4'd3;
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      n_chk++;
      if (bus.offset !== 3'd0) begin
         n_fail++;
         $display("FAIL len_shrink: got %0d want 0", bus.offset);
      end
      bus.len  = 4'd0;
      bus.step = 1'b1;
      cyc();
      cyc();
      bus.step = 1'b0;
      n_chk++;
      if (bus.HEX !== 28'hFFFFFFF || bus.offset !== 3'd0) begin
         n_fail++;
         $display("FAIL len_zero: got hex=%h off=%0d want fffffff 0",
                  bus.HEX, bus.offset);
      end
      bus.len = 4'd2;
      cyc();
      cyc();
      n_chk++;
      if (bus.HEX !== {7'h40, 7'h79, 7'h40, 7'h79}) begin
         n_fail++;
         $display("FAIL len_two_hex0: got %h want %h", bus.HEX,
                  {7'h40, 7'h79, 7'h40, 7'h79});
      end
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      n_chk++;
      if (bus.offset !== 3'd1) begin
         n_fail++;
         $display("FAIL len_two_off: got %0d want 1", bus.offset);
      end
      cyc();
      n_chk++;
      if (bus.HEX !== {7'h79, 7'h40, 7'h79, 7'h40}) begin
         n_fail++;
         $display("FAIL len_two_hex1: got %h want %h", bus.HEX,
                  {7'h79, 7'h40, 7'h79, 7'h40});
      end
      write_buf(6, 5'h06);
      write_buf(7, 5'h07);
      home(9);
      bus.step = 1'b1;
      repeat (7) cyc();
      bus.step = 1'b0;
      n_chk++;
      if (bus.offset !== 3'd7) begin
         n_fail++;
         $display("FAIL len_nine_off7: got %0d want 7", bus.offset);
      end
      cyc();
      n_chk++;
      if (bus.HEX !== {7'h78, 7'h40, 7'h79, 7'h24}) begin
         n_fail++;
         $display("FAIL len_nine_hex: got %h want %h", bus.HEX,
                  {7'h78, 7'h40, 7'h79, 7'h24});
      end
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      n_chk++;
      if (bus.offset !== 3'd0) begin
         n_fail++;
         $display("FAIL len_nine_wrap: got %0d want 0", bus.offset);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [4:0] v;
      home(1);
      e.off = 0;
      e.tk  = 1'b0;
      e.hc  = 1'b1;
      for (int k = 0; k < 17; k++) begin
         v           = 5'(k);
         bus.wr_en   = 1'b1;
         bus.wr_addr = 3'd0;
         bus.wr_data = v;
         e.hx = v[4] ? 28'hFFFFFFF : rep4(seg_tab[v[3:0]]);
         sb.push_back(e);
         cyc();
         if (k > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (bus.HEX !== e.hx) begin
               n_fail++;
               $display("FAIL b2b_hex k=%0d: got %h want %h",
                        k, bus.HEX, e.hx);
            end
         end
      end
      bus.wr_en = 1'b0;
      cyc();
      e = sb.pop_front();
      n_chk++;
      if (bus.HEX !== e.hx) begin
         n_fail++;
         $display("FAIL b2b_hex_last: got %h want %h", bus.HEX, e.hx);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      for (int i = 0; i < 6; i++) begin
         write_buf(i, 5'(i));
      end
      test_scroll("left", 2'b00, '{0, 1, 2, 3, 4, 5, 0}, 18,
                  {7'h19, 7'h12, 7'h40, 7'h79});
      test_scroll("right", 2'b01, '{0, 5, 4, 3, 2, 1, 0}, 6,
                  {7'h12, 7'h40, 7'h79, 7'h24});
      test_scroll("bounce", 2'b10, '{0, 1, 2, 1, 0, 1, 2}, 10,
                  {7'h24, 7'h30, 7'h19, 7'h12});
      test_step();
      test_length();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hex_scroll_display.md
# hex_scroll_display

Parametrised message scroller for the seven-segment bank. It holds a writable buffer of up to `MSG_DEPTH` character codes and shows a `NUM_DISP`-wide window of that buffer on the HEX outputs. The window advances on a programmable tick, moving left, right, or back and forth (bounce); it can also be single-stepped while paused. It sits between the board switch/host write logic and the HEX pins, and replaces the fixed four-display, four-character rotator.

## Interface
- `TICK_CYCLES`, default 50000000: clock cycles per scroll step (≥2).
- `NUM_DISP`, default 4: number of seven-segment displays driven (≥1).
- `MSG_DEPTH`, default 8: character buffer depth (≥2, need not be a power of two). AW = clog2(MSG_DEPTH), LW = clog2(MSG_DEPTH+1).
- `clk`, in, 1: single system clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: buffer write strobe.
- `wr_addr`, in, AW: buffer write index.
- `wr_data`, in, 5: character code. Bit 4 = blank; bits 3:0 = hex digit.
- `len`, in, LW: active message length (0..MSG_DEPTH).
- `mode`, in, 2: scroll pattern. 00 = left, 01 = right, 10 = bounce, 11 = left.
- `run`, in, 1: 1 = auto-scroll on tick, 0 = paused.
- `step`, in, 1: single-cycle pulse; advances one position while paused.
- `HEX`, out, 7*NUM_DISP: active-low segments. [7*NUM_DISP-1 -: 7] is the leftmost display; [6:0] is the rightmost.
- `offset`, out, AW: buffer index currently shown on the leftmost display.
- `tick`, out, 1: one-cycle pulse when the tick counter expires.

## Operation
- **Effective length L:** L = min(len, MSG_DEPTH). If L = 0, all displays show blank (7'h7F) and offset is held at 0.
- **Window:** the leftmost display shows buf[offset]. Each display to its right shows the next index, wrapping to 0 after L-1. If NUM_DISP > L, characters repeat cyclically.
- **Decode, active-low:**
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:18, A:08, b:03, C:46, d:21, E:06, F:0E
  - Bit 4 set → 7F.
- **Writes:**
  - When wr_en=1, buf[wr_addr] ← wr_data on the next edge.
  - wr_addr ≥ MSG_DEPTH is ignored.
  - Writes are independent of scrolling.
- **Tick counter:**
  - While run=1, counts 0..TICK_CYCLES-1, then wraps. tick=1 when count = TICK_CYCLES-1.
  - While run=0, the counter is held at 0 and tick=0.
- **Advance event:** (run & tick) | (~run & step). At most one position per cycle.
- **Left (mode 00/11):** offset ← offset+1, wrapping L-1 → 0.
- **Right (mode 01):** offset ← offset-1, wrapping 0 → L-1.
- **Bounce (mode 10):** internal direction flag dir, with reset value left.
  - M = L - NUM_DISP.
  - If L ≤ NUM_DISP: no movement.
  - If dir = left: offset+1. The flag flips to right in the same cycle offset becomes M.
  - If dir = right: offset-1. The flag flips to left in the same cycle offset becomes 0.
  - If offset > M when entering bounce, the next advance sets offset to M and dir to right.
- **Mode change:** takes effect on the next advance. Offset is not reset.
- **Length change:** if offset ≥ L (new value), offset ← 0 on the next edge. This has priority over an advance in that cycle.
- **Reset:**
  - buf all 5'h10 (blank), offset 0, dir left, counter 0.
  - tick 0, HEX all 7'h7F.

## Timing
- offset and dir update on the edge where the advance event is sampled.
- HEX is registered. It reflects offset, buffer, and len as of the previous edge, so latency is 1 cycle from any offset or buffer change.
- With run held at 1 from reset release, the first tick is at cycle TICK_CYCLES-1. Ticks then recur every TICK_CYCLES cycles.
- Deasserting run mid-count discards the partial count. Reasserting run restarts from 0.
- A step while run=1 is ignored.
- A write and a read of the same entry in the same cycle: the display shows the old value for that cycle and the new value one cycle later.
- rst=1 overrides wr_en, step, and run in the same cycle. Reset asserted mid-scroll yields reset values on the next edge.

## Test plan
- **Reset/blank:** assert rst with wr_en=1 active → HEX = all 7'h7F, offset=0, tick=0. The write is not performed.
- **Left scroll** (TICK_CYCLES=4, NUM_DISP=4, len=6, buf=0..5, run=1, mode=00):
  - tick every 4 cycles.
  - offset sequence 0,1,2,3,4,5,0.
  - At offset=4, HEX left→right = 19,12,40,79.
- **Right scroll** (same setup, mode=01): offset sequence 0,5,4,…; at offset=5, displays show 5,0,1,2.
- **Bounce** (len=6, NUM_DISP=4, mode=10): offset sequence 0,1,2,1,0,1,…; dir flips at offsets 2 and 0.
- **Step and run interplay:**
  - run=0 with three step pulses (mode=00) → offset 0→3, no tick.
  - run=1 with step pulses → offset moves only on tick.
- **Length edge cases:**
  - At offset=5, change len 6→3 → offset=0 next cycle.
  - len=0 → all 7F.
  - len=2 with NUM_DISP=4 → display pattern a,b,a,b.
  - len=9 (>MSG_DEPTH=8) → behaves as len=8.
